ps_stage: RTL
=============

# ps_stage

Program-store lookup stage, directly downstream of the copy stage. It accepts a packet {CG, DEST, DATA}, reads the program-store word at DEST, and emits {CG, NDEST, OPCODE, CPY, DATA} to the next stage. Entries marked invalid drop the packet and are counted. A load port writes the program store while the pipeline is idle. The stage is fully synchronous, with a valid/ready equivalent of the Send/Ack handshake.

## Interface
Parameters:
- CG_W, 4, colour/generation field width
- DEST_W, 7, destination width; the store depth is 2^DEST_W
- OP_W, 6, opcode width
- DATA_W, 16, data field width

Ports:
- CP  in  1  clock; all state changes on its rising edge
- MR_N  in  1  reset, synchronous and active-low
- Send_in  in  1  upstream packet valid
- Ack_out  out  1  ready to upstream; a packet transfers when Send_in && Ack_out at an edge
- PACKET_IN  in  CG_W+DEST_W+DATA_W  {CG, DEST, DATA}
- Send_out  out  1  output packet valid
- Ack_in  in  1  downstream ready; a packet transfers when Send_out && Ack_in
- PACKET_OUT  out  CG_W+DEST_W+OP_W+1+DATA_W  {CG, NDEST, OPCODE, CPY, DATA}
- ld_en  in  1  program-store write request
- ld_addr  in  DEST_W  write address
- ld_data  in  OP_W+DEST_W+2  {V, OPCODE, NDEST, CPY}
- ld_ack  out  1  write performed at this edge (combinational)
- drop_cnt  out  8  count of dropped packets, saturating

## Operation
- Program store: 2^DEST_W words of {V, OPCODE, NDEST, CPY}, with synchronous read. Contents are not cleared by reset.
- Pipeline registers:
  - S1: s1_v plus held CG, DATA, and the read address.
  - OUT: out_v plus the PACKET_OUT register.
- Accept: on transfer, set s1_v, latch CG/DATA, and issue a read at DEST.
- Read-address hold: while S1 is stalled, the read address is held, so the read data stays valid.
- S1 advance: allowed when !out_v || Ack_in.
  - V=1: OUT is loaded with {CG, NDEST, OPCODE, CPY, DATA}; out_v=1.
  - V=0: the packet is consumed and dropped. OUT is not loaded. drop_cnt increments and saturates at 255.
- Ready: Ack_out = MR_N && !ld_en && (!s1_v || !out_v || Ack_in). Ack_out depends combinationally on Ack_in.
- OUT retire: when Ack_in && out_v and no new load of OUT happens, out_v clears.
- Load:
  - ld_ack = ld_en && !s1_v && !out_v && MR_N.
  - On ld_ack, the word is written at the edge.
  - While ld_en is high, Ack_out=0, so load and accept never coincide.
  - ld_en held with the pipeline busy waits until the pipeline drains.
- NDEST is passed as stored, with no arithmetic. Destination increment remains the copy stage's job.

## Timing
- Reset (MR_N=0 at an edge): s1_v=0, out_v=0, PACKET_OUT=0, drop_cnt=0. Ack_out=0 and ld_ack=0 while MR_N=0. The store is untouched.
- Reset mid-operation: in-flight packets are discarded. No Send_out is emitted for them.
- Latency: accept at edge k gives Send_out=1 after edge k+1 (2-cycle pipeline). Dropped packets produce no output.
- Throughput: 1 packet/cycle with Ack_in held high.
- Simultaneous retire and load of OUT: OUT takes the new packet and out_v stays 1.
- Stall: with out_v=1, Ack_in=0 and s1_v=1, Ack_out=0. PACKET_OUT must stay stable until transferred.
- Drop while OUT is stalled: a V=0 packet in S1 still waits for !out_v || Ack_in before being consumed. Packet order is preserved.
- Write-then-read: a packet accepted at the edge after ld_ack sees the new word.

## Structure
- Shared package/header:
  - CG_W, DEST_W, OP_W, DATA_W.
  - Packet field slice macros for input, output and PS word layouts.
  - PS word width, alongside the existing COPY field macros.
- One sub-module, ps_ram: single-port write / sync-read array with read-address register, no reset.
- Pipeline control and drop counter live in ps_stage.

## Test plan
- Load addr 0x05 with {V=1, OP=0x12, NDEST=0x20, CPY=1}. Send {CG=3, DEST=0x05, DATA=0xBEEF} -> Send_out two edges after accept; PACKET_OUT = {3, 0x20, 0x12, 1, 0xBEEF}.
- Stream 8 back-to-back packets to valid entries with Ack_in=1 -> 8 outputs on consecutive cycles, in order, Ack_out constantly 1.
- Hold Ack_in=0 for 5 cycles with 3 packets offered -> Ack_out drops once S1 and OUT are full. PACKET_OUT is stable. After release, all 3 emerge in order, with none lost or duplicated.
- Entry 0x07 with V=0. Send 300 packets to DEST=0x07 -> no Send_out; drop_cnt reaches 255 and holds.
- Assert ld_en with a packet in flight -> ld_ack=0 and Ack_out=0 until drained. ld_ack then pulses one cycle, and the next packet reads the new word.
- Pull MR_N low with S1 and OUT full -> after the edge: Send_out=0, PACKET_OUT=0, drop_cnt=0. Store contents are preserved, and a post-reset lookup returns the previously loaded word.

Source files
------------

// File: rtl/ps_stage_pkg.sv
// Shared widths and packed payload layouts for the program-store lookup stage.
// Input packet, output packet and program-store word are kept together so the layouts stay in step.
package ps_stage_pkg;

    localparam int unsigned CG_W      = 4;
    localparam int unsigned DEST_W    = 7;
    localparam int unsigned OP_W      = 6;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned DROP_W    = 8;

    localparam int unsigned PS_DEPTH  = 1 << DEST_W;
    localparam int unsigned PKT_IN_W  = CG_W + DEST_W + DATA_W;
    localparam int unsigned PKT_OUT_W = CG_W + DEST_W + OP_W + 1 + DATA_W;
    localparam int unsigned PS_WORD_W = OP_W + DEST_W + 2;

    // Packet arriving from the copy stage.
    typedef struct packed {
        logic [CG_W-1:0]   cg;
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } pkt_in_t;

    // Packet handed to the next stage.
    typedef struct packed {
        logic [CG_W-1:0]   cg;
        logic [DEST_W-1:0] ndest;
        logic [OP_W-1:0]   opcode;
        logic              cpy;
        logic [DATA_W-1:0] data;
    } pkt_out_t;

    // One program-store entry; v=0 marks the destination as unused.
    typedef struct packed {
        logic              v;
        logic [OP_W-1:0]   opcode;
        logic [DEST_W-1:0] ndest;
        logic              cpy;
    } ps_word_t;

    // NDEST is forwarded exactly as stored; incrementing it belongs upstream.
    function automatic pkt_out_t make_out(input logic [CG_W-1:0]   cg,
                                          input logic [DATA_W-1:0] data,
                                          input ps_word_t          word);
        pkt_out_t p;
        p.cg     = cg;
        p.ndest  = word.ndest;
        p.opcode = word.opcode;
        p.cpy    = word.cpy;
        p.data   = data;
        return p;
    endfunction

endpackage

// File: rtl/ps_ram.sv
// Program store: single write port, synchronous read through a held read-address register.
// No reset, so loaded contents survive a pipeline reset.
module ps_ram
    import ps_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 we,
    input  logic [DEST_W-1:0]    wr_addr,
    input  logic [PS_WORD_W-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [DEST_W-1:0]    rd_addr,
    output logic [PS_WORD_W-1:0] rd_data
);

    logic [PS_WORD_W-1:0] mem [PS_DEPTH];
    logic [DEST_W-1:0]    rd_addr_q;

    // Address only moves on a new read, so the word stays valid while the consumer stalls.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_addr_q <= rd_addr;
        end
    end

    assign rd_data = mem[rd_addr_q];

endmodule

// File: rtl/ps_stage.sv
// Program-store lookup stage: S1 holds the packet while the store is read, OUT presents the result.
// Packets that hit an invalid entry are consumed in order and counted instead of forwarded.
module ps_stage
    import ps_stage_pkg::*;
(
    input  logic                 CP,
    input  logic                 MR_N,
    input  logic                 Send_in,
    output logic                 Ack_out,
    input  logic [PKT_IN_W-1:0]  PACKET_IN,
    output logic                 Send_out,
    input  logic                 Ack_in,
    output logic [PKT_OUT_W-1:0] PACKET_OUT,
    input  logic                 ld_en,
    input  logic [DEST_W-1:0]    ld_addr,
    input  logic [PS_WORD_W-1:0] ld_data,
    output logic                 ld_ack,
    output logic [DROP_W-1:0]    drop_cnt
);

    pkt_in_t              pkt_in;
    ps_word_t             rd_word;
    logic [PS_WORD_W-1:0] rd_data;

    logic                 s1_v;
    logic [CG_W-1:0]      s1_cg;
    logic [DATA_W-1:0]    s1_data;

    logic                 out_v;
    pkt_out_t             out_q;
    logic [DROP_W-1:0]    drop_q;

    logic                 out_free;
    logic                 accept;
    logic                 advance;

    assign pkt_in  = pkt_in_t'(PACKET_IN);
    assign rd_word = ps_word_t'(rd_data);

    // Handshake: ld_en closes the input so a store write never races a lookup.
    assign out_free = !out_v || Ack_in;
    assign Ack_out  = MR_N && !ld_en && (!s1_v || out_free);
    assign ld_ack   = MR_N && ld_en && !s1_v && !out_v;
    assign accept   = Send_in && Ack_out;
    assign advance  = s1_v && out_free;

    ps_ram u_ps_ram (
        .clk     (CP),
        .we      (ld_ack),
        .wr_addr (ld_addr),
        .wr_data (ld_data),
        .rd_en   (accept),
        .rd_addr (pkt_in.dest),
        .rd_data (rd_data)
    );

    // Pipeline valids, output register and drop counter.
    always_ff @(posedge CP) begin
        if (!MR_N) begin
            s1_v   <= 1'b0;
            out_v  <= 1'b0;
            out_q  <= '0;
            drop_q <= '0;
        end else begin
            if (accept) begin
                s1_v <= 1'b1;
            end else if (advance) begin
                s1_v <= 1'b0;
            end

            if (advance && rd_word.v) begin
                out_v <= 1'b1;
                out_q <= make_out(s1_cg, s1_data, rd_word);
            end else if (Ack_in) begin
                out_v <= 1'b0;
            end

            if (advance && !rd_word.v && (drop_q != {DROP_W{1'b1}})) begin
                drop_q <= drop_q + DROP_W'(1);
            end
        end
    end

    // S1 payload is qualified by s1_v and needs no reset.
    always_ff @(posedge CP) begin
        if (accept) begin
            s1_cg   <= pkt_in.cg;
            s1_data <= pkt_in.data;
        end
    end

    assign Send_out   = out_v;
    assign PACKET_OUT = out_q;
    assign drop_cnt   = drop_q;

endmodule
